// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with start-bit validation and
// framing-error detection. The asynchronous rx pin is synchronised through
// two flops before use.
//
// Optional feature: define UART_RX_PARITY_EN to add a parity bit between the
// data bits and the stop bit (PARITY_ODD selects odd/even).
//
// Ports:
//   clk       - system clock, all logic on rising edge
//   rst_n     - asynchronous active-low reset
//   rx        - serial input, idles high
//   dout      - last good received word, held until the next good frame
//   rx_done   - one-cycle pulse, dout valid in that cycle
//   frame_err - one-cycle pulse on bad stop bit (or bad parity)
//   busy      - high whenever the receiver is not in IDLE
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rx_done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SMP_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [SMP_W-1:0]      smp_q, smp_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  perr_q, perr_d;
  logic                  rx_meta_q, rx_s_q;
  logic                  tick;

  // Free-running oversample tick; with DIV==1 it fires every cycle.
  assign tick  = (div_q == DIV_W'(DIV - 1));
  assign div_d = tick ? '0 : div_q + DIV_W'(1);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          smp_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (smp_q == SMP_MID) begin
            // Mid start bit: a high line means the falling edge was a glitch.
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              smp_d   = '0;
              state_d = DATA;
            end
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (smp_q == SMP_LAST) begin
            smp_d   = '0;
            shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (smp_q == SMP_LAST) begin
            smp_d   = '0;
            perr_d  = rx_s_q != ((^shift_q) ^ (PARITY_ODD != 0));
            state_d = STOP;
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (smp_q == SMP_LAST) begin
            smp_d = '0;
            if (rx_s_q && !perr_q) begin
              dout_d  = shift_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end
          end else begin
            smp_d = smp_q + SMP_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      smp_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      smp_q     <= smp_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign dout      = dout_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 16 clocks per bit. Expected bytes
// are queued when a frame is driven and popped when rx_done pulses.
module tb_uart_rx;

  localparam int unsigned BIT_CLKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         n_ferr = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .DATA_WIDTH(8),
    .OVERSAMPLE(16),
    .PARITY_ODD(0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .dout     (dout),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int nbits);
    rx = v;
    repeat (BIT_CLKS * nbits) @(negedge clk);
  endtask

  // par_bit is only placed on the line when the parity build is used.
  task automatic send_frame(input logic [7:0] data, input logic par_bit,
                            input logic stop_lvl, input int stop_bits, input bit expect_ok);
    if (expect_ok) exp_q.push_back(data);
    drive_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) drive_bit(data[i], 1);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit, 1);
`endif
    drive_bit(stop_lvl, stop_bits);
    rx = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] data);
    send_frame(data, ^data, 1'b1, 1, 1'b1);
  endtask

  // Scoreboard: compare each rx_done against the oldest queued byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_done || frame_err) check("done_ferr_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      if (rx_done) begin
        n_done++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_rx_done: observed dout %0h expected no pulse", dout);
        end
        if (exp_q.size() != 0) begin
          last_good = exp_q.pop_front();
          check("rx_dout", {24'd0, dout}, {24'd0, last_good});
        end
      end
      if (frame_err) begin
        n_ferr++;
        check("dout_held_on_ferr", {24'd0, dout}, {24'd0, last_good});
      end
    end
  end

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    idle(3);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single byte
    send_good(8'h11);
    idle(32);
    check("single_done_cnt", n_done, 1);
    check("single_ferr_cnt", n_ferr, 0);
    check("single_queue_empty", exp_q.size(), 0);

    // Back-to-back, single stop bit, no idle gap
    send_good(8'h12);
    send_good(8'hA5);
    send_good(8'h1B);
    idle(32);
    check("b2b_done_cnt", n_done, 4);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Glitch shorter than half a bit
    rx = 1'b0;
    idle(4);
    check("glitch_busy_rise", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (busy) @(negedge clk);
    end
    check("glitch_busy_fall", {31'd0, busy}, 32'd0);
    idle(32);
    check("glitch_done_cnt", n_done, 4);
    check("glitch_ferr_cnt", n_ferr, 0);

    // Bad stop bit held low for 3 bit times
    send_frame(8'h55, ^8'h55, 1'b0, 3, 1'b0);
    idle(32);
    check("badstop_ferr_cnt", n_ferr, 1);
    check("badstop_done_cnt", n_done, 4);
    check("badstop_dout", {24'd0, dout}, 32'h1B);
    send_good(8'h3C);
    idle(32);
    check("after_badstop_done_cnt", n_done, 5);
    check("after_badstop_queue", exp_q.size(), 0);

    // Reset during data bit 4 of 0xFF
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 4);
    idle(BIT_CLKS / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(2);
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_rx_done", {31'd0, rx_done}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    last_good = 8'h00;
    rst_n = 1'b1;
    idle(20);
    check("post_rst_done_cnt", n_done, 5);
    send_good(8'h13);
    idle(32);
    check("post_rst_frame_done_cnt", n_done, 6);
    check("post_rst_queue", exp_q.size(), 0);
    check("post_rst_ferr_cnt", n_ferr, 1);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so a correct parity bit is 1
    send_frame(8'h07, 1'b1, 1'b1, 1, 1'b1);
    idle(32);
    check("parity_ok_done_cnt", n_done, 7);
    send_frame(8'h07, 1'b0, 1'b1, 1, 1'b0);
    idle(32);
    check("parity_bad_ferr_cnt", n_ferr, 2);
    check("parity_bad_done_cnt", n_done, 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
